// File: rtl/uart_tx.sv
// UART serial transmitter: valid/ready word in, framed async serial out.
// Start bit, LSB-first data, optional parity, 1 or 2 stop bits.
module uart_tx #(
    parameter int SYS_CLK_FREQ = 10**6,
    parameter int BAUD_RATE    = 9600,
    parameter int DATA_WIDTH   = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  sys_clk,
    input  logic                  areset_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic                  tx_out,
    output logic                  busy
);

    localparam int CLKS_PER_BIT = SYS_CLK_FREQ / BAUD_RATE;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(DATA_WIDTH + 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("uart_tx: CLKS_PER_BIT must be at least 2");
        end
        if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
            $error("uart_tx: DATA_WIDTH must be 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_tx: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_tx: STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                  state, state_d;
    logic [CW-1:0]           div_cnt, div_cnt_d;
    logic [BW-1:0]           bit_cnt, bit_cnt_d;
    logic [DATA_WIDTH-1:0]   shift_reg, shift_reg_d;
    logic                    par_bit, par_bit_d;
    logic                    tx_d;
    logic                    ready_d;
    logic                    bit_end;

    assign bit_end = (div_cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge sys_clk or negedge areset_n) begin
        if (!areset_n) begin
            state      <= S_IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            par_bit    <= 1'b0;
            tx_out     <= 1'b1;
            data_ready <= 1'b1;
        end else begin
            state      <= state_d;
            div_cnt    <= div_cnt_d;
            bit_cnt    <= bit_cnt_d;
            shift_reg  <= shift_reg_d;
            par_bit    <= par_bit_d;
            tx_out     <= tx_d;
            data_ready <= ready_d;
        end
    end

    always_comb begin
        state_d     = state;
        div_cnt_d   = div_cnt;
        bit_cnt_d   = bit_cnt;
        shift_reg_d = shift_reg;
        par_bit_d   = par_bit;

        unique case (state)
            S_IDLE: begin
                if (data_valid) begin
                    shift_reg_d = data_in;
                    par_bit_d   = (PARITY == 1) ? ~^data_in : ^data_in;
                    div_cnt_d   = '0;
                    bit_cnt_d   = '0;
                    state_d     = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    div_cnt_d = '0;
                    state_d   = S_DATA;
                end else begin
                    div_cnt_d = div_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    div_cnt_d   = '0;
                    shift_reg_d = shift_reg >> 1;
                    bit_cnt_d   = bit_cnt + 1'b1;
                    if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
                    end
                end else begin
                    div_cnt_d = div_cnt + 1'b1;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = S_STOP;
                end else begin
                    div_cnt_d = div_cnt + 1'b1;
                end
            end
            S_STOP: begin
                // bit_cnt counts stop bits here
                if (bit_end) begin
                    div_cnt_d = '0;
                    if (bit_cnt == BW'(STOP_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = S_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt + 1'b1;
                    end
                end else begin
                    div_cnt_d = div_cnt + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Line level is registered from the next state so tx_out never glitches
    always_comb begin
        tx_d    = 1'b1;
        ready_d = (state_d == S_IDLE);
        unique case (state_d)
            S_IDLE:   tx_d = 1'b1;
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_reg_d[0];
            S_PARITY: tx_d = par_bit_d;
            S_STOP:   tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase
    end

    assign busy = ~data_ready;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed vectors, corner sequences
// and random words against a frame-level reference model.
module tb_uart_tx;

    localparam int CPB = 1000000 / 9600;

    logic       clk;
    logic       areset_n;
    logic [7:0] din;
    logic [3:0] vld;
    logic [3:0] rdy;
    logic [3:0] tx;
    logic [3:0] bsy;

    int cfg_par [4] = '{0, 2, 1, 0};
    int cfg_stop[4] = '{1, 1, 1, 2};

    int   n_chk;
    int   n_pass;
    int   cyc;
    int   start_cyc;
    int   last_low;
    logic obs[16];

    typedef struct {
        int         d;
        logic [7:0] data;
        int         par_idx;
        logic       exp_par;
        int         exp_low;
    } vec_t;

    vec_t vecs[4];

    uart_tx u_plain (
        .sys_clk(clk), .areset_n(areset_n), .data_in(din),
        .data_valid(vld[0]), .data_ready(rdy[0]), .tx_out(tx[0]), .busy(bsy[0])
    );
    uart_tx #(.PARITY(2)) u_even (
        .sys_clk(clk), .areset_n(areset_n), .data_in(din),
        .data_valid(vld[1]), .data_ready(rdy[1]), .tx_out(tx[1]), .busy(bsy[1])
    );
    uart_tx #(.PARITY(1)) u_odd (
        .sys_clk(clk), .areset_n(areset_n), .data_in(din),
        .data_valid(vld[2]), .data_ready(rdy[2]), .tx_out(tx[2]), .busy(bsy[2])
    );
    uart_tx #(.STOP_BITS(2)) u_stop2 (
        .sys_clk(clk), .areset_n(areset_n), .data_in(din),
        .data_valid(vld[3]), .data_ready(rdy[3]), .tx_out(tx[3]), .busy(bsy[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input bit ok, input string nm, input int act, input int req);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, req);
    endtask

    // Reference frame: start, data LSB-first, parity from ones count, stops
    task automatic build(input int d, input logic [7:0] w, output logic bits[$]);
        int ones;
        bits.delete();
        bits.push_back(1'b0);
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            bits.push_back(w[i]);
            if (w[i]) ones++;
        end
        if (cfg_par[d] == 2) bits.push_back(ones % 2 == 1);
        if (cfg_par[d] == 1) bits.push_back(ones % 2 == 0);
        for (int s = 0; s < cfg_stop[d]; s++) bits.push_back(1'b1);
    endtask

    task automatic send(input int d, input logic [7:0] w, input bit keep);
        logic exp[$];
        int   to;
        int   mism;
        int   lowc;
        bit   bad_busy;
        build(d, w, exp);
        din    = w;
        vld[d] = 1'b1;
        to = 0;
        while (tx[d] !== 1'b0 && to < 2000) begin
            @(negedge clk);
            to++;
        end
        check(to < 2000, "start_seen", to, 2000);
        if (to >= 2000) begin
            vld[d] = 1'b0;
            return;
        end
        start_cyc = cyc;
        if (!keep) vld[d] = 1'b0;
        lowc     = 0;
        bad_busy = 1'b0;
        for (int b = 0; b < exp.size(); b++) begin
            mism = 0;
            for (int c = 0; c < CPB; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                if (tx[d] !== exp[b]) mism++;
                if (c == CPB / 2) obs[b] = tx[d];
                if (rdy[d] === 1'b0) lowc++;
                if (bsy[d] !== ~rdy[d]) bad_busy = 1'b1;
                if (b == 4 && c == 0) din = 8'($urandom);
            end
            check(mism == 0, "frame_bit", int'(obs[b]), int'(exp[b]));
        end
        @(negedge clk);
        last_low = lowc;
        check(lowc == exp.size() * CPB && rdy[d] === 1'b1,
              "ready_low_cycles", lowc, exp.size() * CPB);
        check(tx[d] === 1'b1, "idle_gap", int'(tx[d]), 1);
        check(!bad_busy, "busy_vs_ready", int'(bad_busy), 0);
    endtask

    initial begin
        int e_tx;
        int e_rdy;
        int e_bsy;
        int s1;
        int to;
        n_chk    = 0;
        n_pass   = 0;
        areset_n = 1'b0;
        vld      = '0;
        din      = '0;

        vecs[0] = '{d: 0, data: 8'hA5, par_idx: -1, exp_par: 1'b0, exp_low: 1040};
        vecs[1] = '{d: 1, data: 8'h07, par_idx: 9,  exp_par: 1'b1, exp_low: 1144};
        vecs[2] = '{d: 2, data: 8'h07, par_idx: 9,  exp_par: 1'b0, exp_low: 1144};
        vecs[3] = '{d: 3, data: 8'h00, par_idx: -1, exp_par: 1'b0, exp_low: 1144};

        repeat (5) @(negedge clk);
        check(tx === 4'hF && rdy === 4'hF && bsy === 4'h0, "in_reset",
              int'({tx, rdy, bsy}), 12'hFF0);
        areset_n = 1'b1;
        e_tx = 0; e_rdy = 0; e_bsy = 0;
        repeat (2000) begin
            @(negedge clk);
            if (tx !== 4'hF) e_tx++;
            if (rdy !== 4'hF) e_rdy++;
            if (bsy !== 4'h0) e_bsy++;
        end
        check(e_tx == 0, "reset_tx_idle", e_tx, 0);
        check(e_rdy == 0, "reset_ready", e_rdy, 0);
        check(e_bsy == 0, "reset_busy", e_bsy, 0);

        foreach (vecs[i]) begin
            send(vecs[i].d, vecs[i].data, 1'b0);
            check(last_low == vecs[i].exp_low, "vec_ready_low", last_low, vecs[i].exp_low);
            if (vecs[i].par_idx >= 0)
                check(obs[vecs[i].par_idx] === vecs[i].exp_par, "vec_parity",
                      int'(obs[vecs[i].par_idx]), int'(vecs[i].exp_par));
        end

        send(0, 8'h55, 1'b1);
        s1 = start_cyc;
        send(0, 8'hAA, 1'b0);
        check(start_cyc - s1 == 1041, "b2b_spacing", start_cyc - s1, 1041);
        to = 0;
        repeat (1200) begin
            @(negedge clk);
            if (tx[0] !== 1'b1) to++;
        end
        check(to == 0, "no_repeat_frame", to, 0);

        din = 8'hFF;
        vld[0] = 1'b1;
        to = 0;
        while (tx[0] !== 1'b0 && to < 100) begin
            @(negedge clk);
            to++;
        end
        vld[0] = 1'b0;
        repeat (4 * CPB + 50) @(negedge clk);
        check(rdy[0] === 1'b0, "midframe_busy", int'(rdy[0]), 0);
        areset_n = 1'b0;
        #1;
        check(tx[0] === 1'b1 && rdy[0] === 1'b1 && bsy[0] === 1'b0,
              "async_reset_data", int'({tx[0], rdy[0], bsy[0]}), 6);
        repeat (3) @(negedge clk);
        areset_n = 1'b1;
        @(negedge clk);
        check(rdy[0] === 1'b1 && tx[0] === 1'b1, "ready_after_reset",
              int'({tx[0], rdy[0]}), 3);
        send(0, 8'h3C, 1'b0);

        din = 8'h81;
        vld[0] = 1'b1;
        to = 0;
        while (tx[0] !== 1'b0 && to < 100) begin
            @(negedge clk);
            to++;
        end
        vld[0] = 1'b0;
        repeat (20) @(negedge clk);
        areset_n = 1'b0;
        #1;
        check(tx[0] === 1'b1, "async_reset_start", int'(tx[0]), 1);
        @(negedge clk);
        areset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++)
            send(0, 8'($urandom), (i != 7) && ($urandom_range(0, 1) == 1));
        for (int d = 1; d < 4; d++)
            for (int i = 0; i < 4; i++)
                send(d, 8'($urandom), (i != 3) && ($urandom_range(0, 1) == 1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
